// File: rtl/proc_pkg.sv
// Shared filter-processor definitions: opcodes, compare sub-ops, instruction field layout.
// Pure declarations, no logic; no latency or backpressure of its own.
// Imported by the fetch path and the decoder.
package proc_pkg;

    localparam int INSTR_W = 24;
    localparam int OPC_W   = 4;
    localparam int CMP_W   = 2;
    localparam int OPC_MSB = 23;
    localparam int OPC_LSB = 20;
    localparam int CMP_MSB = 19;
    localparam int CMP_LSB = 18;
    localparam int OPND_W  = INSTR_W - OPC_W - CMP_W;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SLR = 4'd10,
        OP_LD  = 4'd12,
        OP_ST  = 4'd13,
        OP_BT  = 4'd14,
        OP_NOP = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        CMP_NOP = 2'd0,
        CMP_LT  = 2'd1,
        CMP_EQ  = 2'd2,
        CMP_LE  = 2'd3
    } cmp_e;

endpackage

// File: rtl/fetch_buffer.sv
// 2-entry prefetch FIFO with synchronous flush; head is visible combinationally.
// Push-to-head latency 1 cycle; flush wins over push and pop in the same cycle.
// No internal backpressure: the caller never pushes into a full buffer.
module fetch_buffer #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] head_dat_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && !flush_i && count_q == 2'd2));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing: owns the PC, presents buffered words to decode (FETCH_PERF_CNT_EN adds perf counters).
// Request at N is presented from N+2; 1 instr/cycle sustained; taken branch re-presents at target after 3 cycles.
// Decode stall (instr_ready=0) is absorbed by a 2-entry buffer; requests stop once buffer + in-flight reach 2.
module fetch_sequencer #(
    parameter int              PC_W     = 10,
    parameter int              INSTR_W  = proc_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                br_taken,
    input  logic [PC_W-1:0]     br_target,
    input  logic                instr_ready,
    output logic                instr_valid,
    output logic [3:0]          opcode,
    output logic [1:0]          cmp_flag,
    output logic [INSTR_W-7:0]  operand,
    output logic [PC_W-1:0]     instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_issued,
    output logic [31:0]         perf_flushed
`endif
);

    import proc_pkg::*;

    localparam int EW = INSTR_W + PC_W;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic               inflight_q;
    logic [PC_W-1:0]    inflight_pc_q;
    logic               run_q;
    logic [1:0]         count;
    logic [EW-1:0]      head_dat;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    head_pc;
    logic               pop;
    logic               push;
    logic               resp_kill;
    logic               req;
    logic [2:0]         occ;

    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid && instr_ready && !br_taken;
    // The response landing in a branch cycle belongs to the old path.
    assign resp_kill   = br_taken && inflight_q;
    assign push        = inflight_q && !resp_kill;
    assign occ         = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
    // run_q holds off the first request until one cycle after reset release.
    assign req         = run_q && !br_taken && (occ < 3'd2);

    assign imem_req  = req;
    assign imem_addr = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (br_taken) begin
            pc_d = br_target;
        end else if (req) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            run_q         <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= req;
            run_q      <= 1'b1;
            if (req) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    fetch_buffer #(
        .W (EW)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i ({imem_rdata, inflight_pc_q}),
        .pop_i      (pop),
        .flush_i    (br_taken),
        .head_dat_o (head_dat),
        .count_o    (count)
    );

    assign head_instr = head_dat[EW-1 -: INSTR_W];
    assign head_pc    = head_dat[PC_W-1:0];

    assign opcode   = instr_valid ? head_instr[INSTR_W-1 -: OPC_W]       : OP_NOP;
    assign cmp_flag = instr_valid ? head_instr[INSTR_W-OPC_W-1 -: CMP_W] : CMP_NOP;
    assign operand  = instr_valid ? head_instr[INSTR_W-7:0]             : '0;
    assign instr_pc = instr_valid ? head_pc                              : pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] issued_q;
    logic [31:0] flushed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q  <= 32'd0;
            flushed_q <= 32'd0;
        end else begin
            issued_q <= issued_q + {31'd0, pop};
            if (br_taken) begin
                flushed_q <= flushed_q + {30'd0, count} + {31'd0, resp_kill};
            end
        end
    end

    assign perf_issued  = issued_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, streaming, stall, redirects, PC wrap, mid-stream reset.
// Instruction memory is a one-cycle read model whose word encodes its own address.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [23:0] imem_rdata;
    logic        br_taken;
    logic [9:0]  br_target;
    logic        instr_ready;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [1:0]  cmp_flag;
    logic [17:0] operand;
    logic [9:0]  instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_flushed;
`endif

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .PC_W     (10),
        .INSTR_W  (24),
        .RESET_PC (10'd0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .cmp_flag    (cmp_flag),
        .operand     (operand),
        .instr_pc    (instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_issued (perf_issued),
        .perf_flushed(perf_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word at address a: opcode a[3:0], cmp a[1:0], operand {8'hA5, a}.
    function automatic logic [23:0] word(input logic [9:0] a);
        return {a[3:0], a[1:0], 8'hA5, a};
    endfunction

    initial imem_rdata = 24'd0;
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= word(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle forward; br_taken is a single-cycle pulse.
    task automatic step();
        @(posedge clk);
        #1 br_taken = 1'b0;
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},     {31'd0, imem_req},    32'd0);
        chk({tag, "_addr"},    {22'd0, imem_addr},   32'd0);
        chk({tag, "_valid"},   {31'd0, instr_valid}, 32'd0);
        chk({tag, "_opcode"},  {28'd0, opcode},      32'hF);
        chk({tag, "_cmp"},     {30'd0, cmp_flag},    32'd0);
        chk({tag, "_operand"}, {14'd0, operand},     32'd0);
        chk({tag, "_pc"},      {22'd0, instr_pc},    32'd0);
    endtask

    task automatic chk_present(input string tag, input logic [9:0] pc, input logic [3:0] opc);
        chk({tag, "_valid"},  {31'd0, instr_valid}, 32'd1);
        chk({tag, "_pc"},     {22'd0, instr_pc},    {22'd0, pc});
        chk({tag, "_opcode"}, {28'd0, opcode},      {28'd0, opc});
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_ready = 1'b1;
        br_taken    = 1'b0;
        br_target   = 10'd0;
        #3;
        chk_reset_outputs("reset");

        // Release reset: cycle 0.
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("c0_req", {31'd0, imem_req}, 32'd0);
        step(); // cycle 1
        chk("c1_req",   {31'd0, imem_req},    32'd1);
        chk("c1_addr",  {22'd0, imem_addr},   32'd0);
        chk("c1_valid", {31'd0, instr_valid}, 32'd0);
        step(); // cycle 2
        chk("c2_addr",  {22'd0, imem_addr},   32'd1);
        chk("c2_valid", {31'd0, instr_valid}, 32'd0);
        step(); // cycle 3
        chk_present("c3", 10'd0, 4'd0);
        chk("c3_cmp",     {30'd0, cmp_flag}, 32'd0);
        chk("c3_operand", {14'd0, operand},  32'h29400);
        chk("c3_addr",    {22'd0, imem_addr}, 32'd2);
        step(); // cycle 4
        chk_present("c4", 10'd1, 4'd1);
        chk("c4_cmp", {30'd0, cmp_flag}, 32'd1);
        step(); // cycle 5
        chk_present("c5", 10'd2, 4'd2);

        // Stall: buffer fills to 2 and requests stop.
        instr_ready = 1'b0;
        #1;
        chk("stall_req_now", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(); // cycles 6..10
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_pc",  {22'd0, instr_pc}, 32'd2);
        end
        instr_ready = 1'b1;
        #1;
        chk("release_req",  {31'd0, imem_req},  32'd1);
        chk("release_addr", {22'd0, imem_addr}, 32'd4);
        step(); // cycle 11
        chk_present("c11", 10'd3, 4'd3);
        step(); // cycle 12
        chk_present("c12", 10'd4, 4'd4);
        step(); // cycle 13
        chk_present("c13", 10'd5, 4'd5);

        // Redirect with two entries buffered.
        instr_ready = 1'b0;
        step(); // cycle 14
        chk_present("c14", 10'd5, 4'd5);
        br_taken  = 1'b1;
        br_target = 10'h040;
        #1;
        chk("br_req_suppressed", {31'd0, imem_req}, 32'd0);
        step(); // cycle 15
        chk("br1_valid", {31'd0, instr_valid}, 32'd0);
        chk("br1_req",   {31'd0, imem_req},    32'd1);
        chk("br1_addr",  {22'd0, imem_addr},   32'h040);
        step(); // cycle 16
        chk("br2_valid", {31'd0, instr_valid}, 32'd0);
        chk("br2_addr",  {22'd0, imem_addr},   32'h041);
        step(); // cycle 17
        chk_present("br3", 10'h040, 4'd0);
        instr_ready = 1'b1;
        step(); // cycle 18
        chk_present("c18", 10'h041, 4'd1);

        // Branch beats handshake; target at the top of memory wraps.
        br_taken  = 1'b1;
        br_target = 10'h3FF;
        step(); // cycle 19
        chk("bh_valid", {31'd0, instr_valid}, 32'd0);
        chk("bh_addr",  {22'd0, imem_addr},   32'h3FF);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_issued",  perf_issued,  32'd6);
        chk("perf_flushed", perf_flushed, 32'd4);
`endif
        step(); // cycle 20
        chk("wrap_addr", {22'd0, imem_addr}, 32'd0);
        chk("wrap_req",  {31'd0, imem_req},  32'd1);
        step(); // cycle 21
        chk_present("c21", 10'h3FF, 4'hF);
        chk("c21_cmp",     {30'd0, cmp_flag}, 32'd3);
        chk("c21_operand", {14'd0, operand},  32'h297FF);
        step(); // cycle 22
        chk_present("c22", 10'd0, 4'd0);

        // Back-to-back branches: the second target wins.
        br_taken  = 1'b1;
        br_target = 10'h100;
        step(); // cycle 23
        br_taken  = 1'b1;
        br_target = 10'h200;
        #1;
        chk("b2b_req",   {31'd0, imem_req},    32'd0);
        chk("b2b_valid", {31'd0, instr_valid}, 32'd0);
        step(); // cycle 24
        chk("b2b_addr", {22'd0, imem_addr}, 32'h200);
        chk("b2b_req1", {31'd0, imem_req},  32'd1);
        step(); // cycle 25
        chk("b2b_addr2", {22'd0, imem_addr}, 32'h201);
        step(); // cycle 26
        chk_present("c26", 10'h200, 4'd0);

        // Mid-stream reset acts immediately and fetch restarts at address 0.
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
`ifdef FETCH_PERF_CNT_EN
        chk("midrst_issued", perf_issued, 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("r0_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("r1_req",  {31'd0, imem_req},  32'd1);
        chk("r1_addr", {22'd0, imem_addr}, 32'd0);
        step();
        chk("r2_valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk_present("r3", 10'd0, 4'd0);
        step();
        chk_present("r4", 10'd1, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
